// File: rtl/load_store_queue_unit.sv
// load_store_queue_unit: AGU + DEPTH-entry in-order request queue feeding ROB stores, store forwarding, cache loads.
// Define LSU_MISALIGN_EXC_EN to turn unaligned H/W head accesses into address-misaligned exceptions.
module load_store_queue_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 32,
    parameter int R_WIDTH    = 6,
    parameter int MICROOP    = 5,
    parameter int ROB_TICKET = 3,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [MICROOP-1:0]    in_microop,
    input  logic [ROB_TICKET-1:0] in_ticket,
    input  logic [R_WIDTH-1:0]    in_dest,
    input  logic                  flush_valid,
    output logic                  busy_fu,
    output logic [ADDR_BITS-1:0]  frw_address,
    output logic [MICROOP-1:0]    frw_microop,
    input  logic [DATA_WIDTH-1:0] frw_data,
    input  logic                  frw_valid,
    input  logic                  frw_stall,
    input  logic                  cache_writeback_valid,
    input  logic                  cache_blocked,
    output logic                  store_valid,
    output logic [ADDR_BITS-1:0]  store_address,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [MICROOP-1:0]    store_microop,
    output logic [ROB_TICKET-1:0] store_ticket,
    output logic                  cache_load_valid,
    output logic [ADDR_BITS-1:0]  cache_load_addr,
    output logic [R_WIDTH-1:0]    cache_load_dest,
    output logic [MICROOP-1:0]    cache_load_microop,
    output logic [ROB_TICKET-1:0] cache_load_ticket,
    input  logic                  cache_fu_valid,
    input  logic [R_WIDTH-1:0]    cache_fu_dest,
    input  logic [ROB_TICKET-1:0] cache_fu_ticket,
    input  logic [DATA_WIDTH-1:0] cache_fu_data,
    input  logic                  cache_fu_exc,
    input  logic [3:0]            cache_fu_cause,
    output logic                  fu_valid,
    output logic [R_WIDTH-1:0]    fu_dest,
    output logic [ROB_TICKET-1:0] fu_ticket,
    output logic [DATA_WIDTH-1:0] fu_data,
    output logic                  fu_exc,
    output logic [3:0]            fu_cause,
    output logic                  output_used
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LB = $clog2(DATA_WIDTH / 8);
    localparam logic [MICROOP-1:0] OP_LW  = MICROOP'(1);
    localparam logic [MICROOP-1:0] OP_LH  = MICROOP'(2);
    localparam logic [MICROOP-1:0] OP_LHU = MICROOP'(3);
    localparam logic [MICROOP-1:0] OP_LB  = MICROOP'(4);
    localparam logic [MICROOP-1:0] OP_LBU = MICROOP'(5);
    localparam logic [MICROOP-1:0] OP_SW  = MICROOP'(6);
    localparam logic [MICROOP-1:0] OP_SH  = MICROOP'(7);
    localparam logic [MICROOP-1:0] OP_SB  = MICROOP'(8);

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
        logic [MICROOP-1:0]    op;
        logic [ROB_TICKET-1:0] ticket;
        logic [R_WIDTH-1:0]    dest;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          hd, new_ent;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr, pop, empty, port_free, h_store;
    logic [LB-1:0]   lane;
    logic [DATA_WIDTH-1:0] sh, fwd_data;
    logic            int_exc;
    logic [3:0]      int_cause;
    logic [DATA_WIDTH-1:0] int_data;
`ifdef LSU_MISALIGN_EXC_EN
    logic            mis;
`endif

    assign busy_fu   = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign wr        = in_valid & ~busy_fu & ~flush_valid;
    assign port_free = ~cache_writeback_valid & ~cache_blocked;
    assign hd        = ent_q[head_q];
    assign lane      = hd.addr[LB-1:0];
    assign h_store   = hd.op == OP_SW || hd.op == OP_SH || hd.op == OP_SB;
    assign sh        = frw_data >> {lane, 3'b000};
`ifdef LSU_MISALIGN_EXC_EN
    assign mis = ((hd.op == OP_LH || hd.op == OP_LHU || hd.op == OP_SH) && hd.addr[0])
               || ((hd.op == OP_LW || hd.op == OP_SW) && lane != '0);
`endif

    always_comb begin
        new_ent        = '0;
        new_ent.addr   = ADDR_BITS'(in_data1 + in_imm);
        new_ent.data   = in_data2;
        new_ent.op     = in_microop;
        new_ent.ticket = in_ticket;
        new_ent.dest   = in_dest;
    end

    // Lane-extracted forwarded value; words use the shifted vector so every bit stays live.
    always_comb begin
        fwd_data = sh;
        if (hd.op == OP_LB)  fwd_data = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
        if (hd.op == OP_LBU) fwd_data = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
        if (hd.op == OP_LH)  fwd_data = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
        if (hd.op == OP_LHU) fwd_data = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
    end

    always_comb begin
        pop              = 1'b0;
        store_valid      = 1'b0;
        cache_load_valid = 1'b0;
        output_used      = 1'b0;
        int_exc          = 1'b0;
        int_cause        = 4'd0;
        int_data         = fwd_data;
        if (!empty) begin
`ifdef LSU_MISALIGN_EXC_EN
            if (mis) begin
                if (port_free) begin
                    output_used = 1'b1;
                    int_exc     = 1'b1;
                    int_cause   = h_store ? 4'd6 : 4'd4;
                    int_data    = '0;
                    pop         = 1'b1;
                end
            end else
`endif
            if (h_store) begin
                store_valid = 1'b1;
                pop         = 1'b1;
            end else if (!frw_stall && port_free) begin
                output_used      = frw_valid;
                cache_load_valid = ~frw_valid;
                pop              = 1'b1;
            end
        end
    end

    always_comb begin
        frw_address        = empty ? '0 : hd.addr;
        frw_microop        = empty ? '0 : hd.op;
        store_address      = store_valid ? hd.addr : '0;
        store_data         = store_valid ? hd.data : '0;
        store_microop      = store_valid ? hd.op : '0;
        store_ticket       = store_valid ? hd.ticket : '0;
        cache_load_addr    = cache_load_valid ? hd.addr : '0;
        cache_load_dest    = cache_load_valid ? hd.dest : '0;
        cache_load_microop = cache_load_valid ? hd.op : '0;
        cache_load_ticket  = cache_load_valid ? hd.ticket : '0;
        fu_valid           = output_used ? 1'b1 : cache_fu_valid;
        fu_dest            = output_used ? hd.dest : cache_fu_dest;
        fu_ticket          = output_used ? hd.ticket : cache_fu_ticket;
        fu_data            = output_used ? int_data : cache_fu_data;
        fu_exc             = output_used ? int_exc : cache_fu_exc;
        fu_cause           = output_used ? int_cause : cache_fu_cause;
    end

    always_comb begin
        head_d  = flush_valid ? '0 : head_q + PW'(pop);
        tail_d  = flush_valid ? '0 : tail_q + PW'(wr);
        count_d = flush_valid ? '0 : count_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) ent_q[tail_q] <= new_ent;
    end
endmodule

// File: tb/tb_load_store_queue_unit.sv
// tb_load_store_queue_unit: directed vector table plus hand-written multi-cycle sequences.
module tb_load_store_queue_unit;
    logic        clk, rst, in_valid, flush_valid, busy_fu, frw_valid, frw_stall;
    logic [31:0] in_data1, in_data2, in_imm, frw_address, frw_data;
    logic [4:0]  in_microop, frw_microop;
    logic [2:0]  in_ticket;
    logic [5:0]  in_dest;
    logic        cache_writeback_valid, cache_blocked;
    logic        store_valid, cache_load_valid;
    logic [31:0] store_address, store_data, cache_load_addr;
    logic [4:0]  store_microop, cache_load_microop;
    logic [2:0]  store_ticket, cache_load_ticket;
    logic [5:0]  cache_load_dest;
    logic        cache_fu_valid, cache_fu_exc;
    logic [5:0]  cache_fu_dest;
    logic [2:0]  cache_fu_ticket;
    logic [31:0] cache_fu_data;
    logic [3:0]  cache_fu_cause;
    logic        fu_valid, fu_exc, output_used;
    logic [5:0]  fu_dest;
    logic [2:0]  fu_ticket;
    logic [31:0] fu_data;
    logic [3:0]  fu_cause;
    int n_tests = 0, n_fail = 0;

    load_store_queue_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data1(in_data1), .in_data2(in_data2),
        .in_imm(in_imm), .in_microop(in_microop), .in_ticket(in_ticket), .in_dest(in_dest),
        .flush_valid(flush_valid), .busy_fu(busy_fu), .frw_address(frw_address),
        .frw_microop(frw_microop), .frw_data(frw_data), .frw_valid(frw_valid), .frw_stall(frw_stall),
        .cache_writeback_valid(cache_writeback_valid), .cache_blocked(cache_blocked),
        .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
        .store_microop(store_microop), .store_ticket(store_ticket),
        .cache_load_valid(cache_load_valid), .cache_load_addr(cache_load_addr),
        .cache_load_dest(cache_load_dest), .cache_load_microop(cache_load_microop),
        .cache_load_ticket(cache_load_ticket), .cache_fu_valid(cache_fu_valid),
        .cache_fu_dest(cache_fu_dest), .cache_fu_ticket(cache_fu_ticket),
        .cache_fu_data(cache_fu_data), .cache_fu_exc(cache_fu_exc), .cache_fu_cause(cache_fu_cause),
        .fu_valid(fu_valid), .fu_dest(fu_dest), .fu_ticket(fu_ticket), .fu_data(fu_data),
        .fu_exc(fu_exc), .fu_cause(fu_cause), .output_used(output_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] d1, imm, d2;
        logic        fv;
        logic [31:0] fd;
        logic        sv, clv, fuv, used;
        logic [31:0] fud, addr;
    } vec_t;
    vec_t v[12];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic drive_req(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] imm,
                             input logic [31:0] d2, input logic [2:0] t, input logic [5:0] d);
        in_valid = 1'b1; in_microop = op; in_data1 = d1; in_imm = imm; in_data2 = d2;
        in_ticket = t; in_dest = d;
    endtask

    initial begin
        v[0]  = '{5'd6, 32'h100, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h104};
        v[1]  = '{5'd4, 32'h200, 32'h3, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFF80, 32'h203};
        v[2]  = '{5'd5, 32'h200, 32'h2, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000FF, 32'h202};
        v[3]  = '{5'd4, 32'h1FF, 32'h2, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000012, 32'h201};
        v[4]  = '{5'd2, 32'h200, 32'h2, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF80FF, 32'h202};
        v[5]  = '{5'd3, 32'h200, 32'h2, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000080FF, 32'h202};
        v[6]  = '{5'd2, 32'h200, 32'h0, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00001234, 32'h200};
        v[7]  = '{5'd1, 32'h1F0, 32'h10, 32'h0, 1'b1, 32'h80FF1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80FF1234, 32'h200};
        v[8]  = '{5'd1, 32'h400, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h408};
        v[9]  = '{5'd8, 32'hFFFFFFFF, 32'h2, 32'h55, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1};
        v[10] = '{5'd4, 32'h500, 32'h0, 32'h0, 1'b1, 32'h7F00A5C3, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFC3, 32'h500};
        v[11] = '{5'd3, 32'h500, 32'h2, 32'h0, 1'b1, 32'h7F00A5C3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00007F00, 32'h502};

        rst = 1'b1; in_valid = 0; in_data1 = 0; in_data2 = 0; in_imm = 0; in_microop = 0;
        in_ticket = 0; in_dest = 0; flush_valid = 0; frw_data = 0; frw_valid = 0; frw_stall = 0;
        cache_writeback_valid = 0; cache_blocked = 0; cache_fu_valid = 0; cache_fu_dest = 0;
        cache_fu_ticket = 0; cache_fu_data = 0; cache_fu_exc = 0; cache_fu_cause = 0;
        #12;
        chk("reset busy_fu", busy_fu, 0);
        chk("reset store_valid", store_valid, 0);
        chk("reset cache_load_valid", cache_load_valid, 0);
        chk("reset fu_valid", fu_valid, 0);
        chk("reset frw_address", frw_address, 0);
        @(negedge clk); rst = 1'b0;

        // cache result pass-through on an empty queue
        cache_fu_valid = 1; cache_fu_dest = 6'd9; cache_fu_ticket = 3'd5; cache_fu_data = 32'hCAFE0001;
        #1;
        chk("passthru fu_valid", fu_valid, 1);
        chk("passthru output_used", output_used, 0);
        chk("passthru fu_data", fu_data, 32'hCAFE0001);
        chk("passthru fu_dest", fu_dest, 9);
        cache_fu_valid = 0; cache_fu_dest = 0; cache_fu_ticket = 0; cache_fu_data = 0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_req(v[i].op, v[i].d1, v[i].imm, v[i].d2, 3'(i), 6'(i + 1));
            #1 chk($sformatf("v%0d empty before", i), {store_valid, cache_load_valid, fu_valid}, 0);
            @(negedge clk);
            in_valid = 0; frw_valid = v[i].fv; frw_data = v[i].fd;
            #1;
            chk($sformatf("v%0d store_valid", i), store_valid, v[i].sv);
            chk($sformatf("v%0d cache_load_valid", i), cache_load_valid, v[i].clv);
            chk($sformatf("v%0d fu_valid", i), fu_valid, v[i].fuv);
            chk($sformatf("v%0d output_used", i), output_used, v[i].used);
            chk($sformatf("v%0d frw_address", i), frw_address, v[i].addr);
            if (v[i].fuv) begin
                chk($sformatf("v%0d fu_data", i), fu_data, v[i].fud);
                chk($sformatf("v%0d fu_dest", i), fu_dest, 6'(i + 1));
                chk($sformatf("v%0d fu_exc", i), fu_exc, 0);
            end
            if (v[i].sv) begin
                chk($sformatf("v%0d store_address", i), store_address, v[i].addr);
                chk($sformatf("v%0d store_data", i), store_data, v[i].d2);
                chk($sformatf("v%0d store_ticket", i), store_ticket, 3'(i));
            end
            if (v[i].clv) begin
                chk($sformatf("v%0d cache_load_addr", i), cache_load_addr, v[i].addr);
                chk($sformatf("v%0d cache_load_dest", i), cache_load_dest, 6'(i + 1));
            end
            @(negedge clk);
            frw_valid = 0; frw_data = 0;
            #1 chk($sformatf("v%0d popped", i), {store_valid, cache_load_valid, output_used, busy_fu}, 0);
        end

        // LW held while a committed store owns the cache port
        @(negedge clk);
        drive_req(5'd1, 32'h300, 32'h0, 32'h0, 3'd1, 6'd2);
        cache_writeback_valid = 1;
        @(negedge clk);
        in_valid = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("wb hold%0d cache_load_valid", c), cache_load_valid, 0);
            chk($sformatf("wb hold%0d frw_address", c), frw_address, 32'h300);
            @(negedge clk);
        end
        cache_writeback_valid = 0;
        #1;
        chk("wb release cache_load_valid", cache_load_valid, 1);
        chk("wb release cache_load_addr", cache_load_addr, 32'h300);
        @(negedge clk);
        #1 chk("wb after pop", cache_load_valid, 0);

        // head stalled: fill the queue, fifth request must be dropped
        frw_stall = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_req(5'd1, 32'h10 + 32'(4 * k), 32'h0, 32'h0, 3'(k), 6'(k));
            #1;
            if (k == 3) chk("fill busy after 3", busy_fu, 0);
            if (k == 4) chk("fill busy after 4", busy_fu, 1);
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("fill busy after drop", busy_fu, 1);
        chk("fill stalled no issue", cache_load_valid, 0);
        chk("fill head addr", frw_address, 32'h10);
        frw_stall = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain%0d cache_load_valid", k), cache_load_valid, 1);
            chk($sformatf("drain%0d addr", k), cache_load_addr, 32'h10 + 32'(4 * k));
            @(negedge clk);
        end
        #1 chk("drain fifth dropped", cache_load_valid, 0);

        // flush with two entries queued, then a fresh LW becomes the head
        frw_stall = 1;
        @(negedge clk); drive_req(5'd1, 32'h40, 32'h0, 32'h0, 3'd0, 6'd1);
        @(negedge clk); drive_req(5'd1, 32'h44, 32'h0, 32'h0, 3'd1, 6'd2);
        @(negedge clk); in_valid = 0; flush_valid = 1;
        @(negedge clk); flush_valid = 0;
        #1 chk("flush empty", frw_address, 0);
        drive_req(5'd1, 32'h80, 32'h0, 32'h0, 3'd2, 6'd3);
        @(negedge clk); in_valid = 0; frw_stall = 0;
        #1;
        chk("flush new head valid", cache_load_valid, 1);
        chk("flush new head addr", cache_load_addr, 32'h80);
        @(negedge clk);
        #1 chk("flush no stale", cache_load_valid, 0);

        // asynchronous reset mid-stream with three queued entries
        frw_stall = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive_req(5'd1, 32'h600 + 32'(4 * k), 32'h0, 32'h0, 3'(k), 6'(k));
        end
        @(negedge clk); in_valid = 0;
        #1 chk("pre-reset head", frw_address, 32'h600);
        #1 rst = 1;
        #1;
        chk("midrst frw_address", frw_address, 0);
        chk("midrst busy_fu", busy_fu, 0);
        chk("midrst cache_load_valid", cache_load_valid, 0);
        chk("midrst store_valid", store_valid, 0);
        @(negedge clk); rst = 0; frw_stall = 0;
        #1 chk("post-reset idle", cache_load_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
